// File: rtl/serial_paralelo_rx4.sv
// Serial receive front end: comma-based byte alignment, lock detection and
// round-robin distribution of the received bytes to four 8-bit lanes.
module serial_paralelo_rx4 #(
  parameter logic [7:0]  COM          = 8'hBC,
  parameter int unsigned ACTIVE_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic       active,
  output logic       byte_strobe,
  output logic [1:0] lane_sel,
  output logic [7:0] data_rx0,
  output logic [7:0] data_rx1,
  output logic [7:0] data_rx2,
  output logic [7:0] data_rx3,
  output logic       valid_rx0,
  output logic       valid_rx1,
  output logic       valid_rx2,
  output logic       valid_rx3
);

  localparam logic [1:0] StHunt   = 2'd0;
  localparam logic [1:0] StSync   = 2'd1;
  localparam logic [1:0] StActive = 2'd2;

  localparam logic [3:0] ActiveCnt = 4'(ACTIVE_COUNT);

  logic [1:0] state_q, state_d;
  // Only the seven most recent bits are needed: the candidate byte is
  // always formed with the bit arriving this cycle.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic       active_q, active_d;
  logic       strobe_q, strobe_d;
  logic [1:0] lane_q, lane_d;
  logic [7:0] data_q [4];
  logic [7:0] data_d [4];
  logic [3:0] valid_q, valid_d;

  logic [7:0] nb;
  logic       is_com;
  logic       byte_done;
  logic [3:0] com_cnt_inc;

  assign nb          = {sr_q, data_in};
  assign is_com      = (nb == COM);
  assign byte_done   = (bit_cnt_q == 3'd7);
  assign com_cnt_inc = com_cnt_q + 4'd1;

  always_comb begin
    state_d   = state_q;
    sr_d      = nb[6:0];
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    active_d  = active_q;
    strobe_d  = 1'b0;
    lane_d    = lane_q;
    data_d    = data_q;
    valid_d   = valid_q;

    case (state_q)
      StHunt: begin
        // Bit-sliding search: every edge is a candidate byte boundary.
        if (is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          if (ActiveCnt == 4'd1) begin
            state_d  = StActive;
            active_d = 1'b1;
            lane_d   = 2'd0;
          end else begin
            state_d = StSync;
          end
        end
      end

      StSync: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (is_com) begin
            com_cnt_d = com_cnt_inc;
            if (com_cnt_inc == ActiveCnt) begin
              state_d  = StActive;
              active_d = 1'b1;
              lane_d   = 2'd0;
            end
          end else begin
            state_d   = StHunt;
            com_cnt_d = 4'd0;
          end
        end
      end

      StActive: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          strobe_d = 1'b1;
          // Lane advances on idle slots too, keeping step with the transmitter's mux.
          lane_d   = lane_q + 2'd1;
          if (is_com) begin
            valid_d[lane_q] = 1'b0;
          end else begin
            data_d[lane_q]  = nb;
            valid_d[lane_q] = 1'b1;
          end
        end
      end

      default: begin
        state_d = StHunt;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= StHunt;
      sr_q      <= 7'd0;
      bit_cnt_q <= 3'd0;
      com_cnt_q <= 4'd0;
      active_q  <= 1'b0;
      strobe_q  <= 1'b0;
      lane_q    <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= 8'h00;
      end
      valid_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      active_q  <= active_d;
      strobe_q  <= strobe_d;
      lane_q    <= lane_d;
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q   <= valid_d;
    end
  end

  assign active      = active_q;
  assign byte_strobe = strobe_q;
  assign lane_sel    = lane_q;
  assign data_rx0    = data_q[0];
  assign data_rx1    = data_q[1];
  assign data_rx2    = data_q[2];
  assign data_rx3    = data_q[3];
  assign valid_rx0   = valid_q[0];
  assign valid_rx1   = valid_q[1];
  assign valid_rx2   = valid_q[2];
  assign valid_rx3   = valid_q[3];

endmodule
